// File: rtl/branch_resolve_if.sv
// Bundle between the branch-condition evaluator, the resolve stage, commit and fetch.
// The resolve stage takes the slave view; the driving side takes the master view.
interface branch_resolve_if #(
  parameter int AWID  = 24,
  parameter int TAGW  = 5,
  parameter int DISPW = 12
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [TAGW-1:0]   in_tag_i;
  logic [AWID-1:0]   in_pc_i;
  logic [2:0]        in_len_i;
  logic [DISPW-1:0]  in_disp_i;
  logic              in_takb_i;
  logic              in_pred_i;
  logic [AWID-1:0]   in_pred_pc_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [TAGW-1:0]   out_tag_o;
  logic              out_taken_o;
  logic              out_mispred_o;
  logic              redir_valid_o;
  logic [AWID-1:0]   redir_pc_o;
  logic              redir_ack_i;

  modport slave (
    input  flush_i, in_valid_i, in_tag_i, in_pc_i, in_len_i, in_disp_i,
           in_takb_i, in_pred_i, in_pred_pc_i, out_ready_i, redir_ack_i,
    output in_ready_o, out_valid_o, out_tag_o, out_taken_o, out_mispred_o,
           redir_valid_o, redir_pc_o
  );

  modport master (
    output flush_i, in_valid_i, in_tag_i, in_pc_i, in_len_i, in_disp_i,
           in_takb_i, in_pred_i, in_pred_pc_i, out_ready_i, redir_ack_i,
    input  in_ready_o, out_valid_o, out_tag_o, out_taken_o, out_mispred_o,
           redir_valid_o, redir_pc_o
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolve stage: capture (S1), resolve into registered result (S2),
// and a held redirect to fetch whenever the resolved next PC differs from the prediction.
module branch_resolve #(
  parameter int AWID  = 24,
  parameter int TAGW  = 5,
  parameter int DISPW = 12
) (
  input logic           clk_i,
  input logic           rst_i,
  branch_resolve_if.slave bus
);
  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_reg;
  logic              s1_valid_reg;
  logic [TAGW-1:0]   s1_tag_reg;
  logic [AWID-1:0]   s1_pc_reg;
  logic [2:0]        s1_len_reg;
  logic [DISPW-1:0]  s1_disp_reg;
  logic              s1_takb_reg;
  logic [AWID-1:0]   s1_pred_pc_reg;
  logic              s2_valid_reg;
  logic [TAGW-1:0]   s2_tag_reg;
  logic              s2_taken_reg;
  logic              s2_mispred_reg;
  logic              redir_valid_reg;
  logic [AWID-1:0]   redir_pc_reg;

  logic [AWID-1:0]   fall_addr;
  logic [AWID-1:0]   tgt_addr;
  logic [AWID-1:0]   next_addr;
  logic              mispred_next;
  logic              s1_adv;
  logic              in_fire;
  logic              unused_pred;

  // Only the predicted target decides a mispredict, so the direction bit is not consulted.
  assign unused_pred = bus.in_pred_i;

  assign fall_addr    = s1_pc_reg + {{(AWID-3){1'b0}}, s1_len_reg};
  assign tgt_addr     = fall_addr + {{(AWID-DISPW){s1_disp_reg[DISPW-1]}}, s1_disp_reg};
  assign next_addr    = s1_takb_reg ? tgt_addr : fall_addr;
  assign mispred_next = (next_addr != s1_pred_pc_reg);

  assign s1_adv  = s1_valid_reg && (!s2_valid_reg || bus.out_ready_i);
  assign in_fire = bus.in_valid_i && bus.in_ready_o;

  assign bus.in_ready_o    = (!s1_valid_reg || s1_adv) && (state_reg == IDLE);
  assign bus.out_valid_o   = s2_valid_reg;
  assign bus.out_tag_o     = s2_tag_reg;
  assign bus.out_taken_o   = s2_taken_reg;
  assign bus.out_mispred_o = s2_mispred_reg;
  assign bus.redir_valid_o = redir_valid_reg;
  assign bus.redir_pc_o    = redir_pc_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= IDLE;
      s1_valid_reg    <= 1'b0;
      s1_tag_reg      <= '0;
      s1_pc_reg       <= '0;
      s1_len_reg      <= '0;
      s1_disp_reg     <= '0;
      s1_takb_reg     <= 1'b0;
      s1_pred_pc_reg  <= '0;
      s2_valid_reg    <= 1'b0;
      s2_tag_reg      <= '0;
      s2_taken_reg    <= 1'b0;
      s2_mispred_reg  <= 1'b0;
      redir_valid_reg <= 1'b0;
      redir_pc_reg    <= '0;
    end else if (bus.flush_i) begin
      s1_valid_reg    <= 1'b0;
      s2_valid_reg    <= 1'b0;
      state_reg       <= IDLE;
      redir_valid_reg <= 1'b0;
    end else begin
      // Anything captured alongside a mispredicting resolve is wrong-path and dropped.
      if (s1_adv && mispred_next) begin
        s1_valid_reg <= 1'b0;
      end else if (in_fire) begin
        s1_valid_reg <= 1'b1;
      end else if (s1_adv) begin
        s1_valid_reg <= 1'b0;
      end

      if (in_fire) begin
        s1_tag_reg     <= bus.in_tag_i;
        s1_pc_reg      <= bus.in_pc_i;
        s1_len_reg     <= bus.in_len_i;
        s1_disp_reg    <= bus.in_disp_i;
        s1_takb_reg    <= bus.in_takb_i;
        s1_pred_pc_reg <= bus.in_pred_pc_i;
      end

      if (s1_adv) begin
        s2_valid_reg   <= 1'b1;
        s2_tag_reg     <= s1_tag_reg;
        s2_taken_reg   <= s1_takb_reg;
        s2_mispred_reg <= mispred_next;
      end else if (s2_valid_reg && bus.out_ready_i) begin
        s2_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (s1_adv && mispred_next) begin
            state_reg       <= HOLD;
            redir_valid_reg <= 1'b1;
            redir_pc_reg    <= next_addr;
          end
        end
        HOLD: begin
          if (bus.redir_ack_i) begin
            state_reg       <= IDLE;
            redir_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: results queued at accept, popped by a
// negedge monitor; redirect, stall, flush and reset behaviour checked per task.
`timescale 1ns/1ps
module tb_branch_resolve;
  localparam int AWID  = 24;
  localparam int TAGW  = 5;
  localparam int DISPW = 12;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  branch_resolve_if #(.AWID(AWID), .TAGW(TAGW), .DISPW(DISPW)) bus ();

  branch_resolve #(.AWID(AWID), .TAGW(TAGW), .DISPW(DISPW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int chk_cnt   = 0;
  int pass_cnt  = 0;
  int out_count = 0;
  logic [TAGW+1:0] exp_q[$];
  logic [TAGW+1:0] got_v;
  logic [TAGW+1:0] exp_v;

  function automatic logic [AWID-1:0] model_next(input logic [AWID-1:0] pc, input logic [2:0] len,
                                                 input logic signed [DISPW-1:0] disp, input logic takb);
    longint f;
    longint t;
    logic [AWID-1:0] r;
    f = longint'(pc) + longint'(len);
    t = f + longint'(disp);
    r = takb ? t[AWID-1:0] : f[AWID-1:0];
    return r;
  endfunction

  // Result monitor: every completed output handshake is compared against the queue head.
  always @(negedge clk_i) begin
    if (!rst_i && !bus.flush_i && bus.out_valid_o && bus.out_ready_i) begin
      out_count++;
      chk_cnt++;
      got_v = {bus.out_tag_o, bus.out_taken_o, bus.out_mispred_o};
      if (exp_q.size() == 0) begin
        $display("FAIL result: got tag=%0d taken=%0d mispred=%0d, required no output",
                 bus.out_tag_o, bus.out_taken_o, bus.out_mispred_o);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v)
          $display("FAIL result: got tag=%0d taken=%0d mispred=%0d, required tag=%0d taken=%0d mispred=%0d",
                   got_v[TAGW+1:2], got_v[1], got_v[0], exp_v[TAGW+1:2], exp_v[1], exp_v[0]);
        else begin
          pass_cnt++;
          $display("result tag=%0d taken=%0d mispred=%0d ok", got_v[TAGW+1:2], got_v[1], got_v[0]);
        end
      end
    end
  end

  task automatic send(input logic [TAGW-1:0] tag, input logic [AWID-1:0] pc, input logic [2:0] len,
                      input logic [DISPW-1:0] disp, input logic takb, input logic pred,
                      input logic [AWID-1:0] pred_pc, input bit push, output int waits);
    logic [AWID-1:0] nx;
    bit acc;
    acc   = 1'b0;
    waits = 0;
    bus.in_valid_i   = 1'b1;
    bus.in_tag_i     = tag;
    bus.in_pc_i      = pc;
    bus.in_len_i     = len;
    bus.in_disp_i    = disp;
    bus.in_takb_i    = takb;
    bus.in_pred_i    = pred;
    bus.in_pred_pc_i = pred_pc;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk_i);
      if (bus.in_ready_o) acc = 1'b1;
      else waits++;
      @(posedge clk_i);
      #1;
    end
    bus.in_valid_i = 1'b0;
    chk_cnt++;
    if (!acc) $display("FAIL accept tag=%0d: in_ready=0 for 20 cycles, required 1", tag);
    else begin
      pass_cnt++;
      $display("send tag=%0d pc=%06h waits=%0d", tag, pc, waits);
    end
    if (acc && push) begin
      nx = model_next(pc, len, disp, takb);
      exp_q.push_back({tag, takb, nx != pred_pc});
    end
  endtask

  task automatic test_reset();
    @(posedge clk_i); #1;
    chk_cnt++;
    if ({bus.out_valid_o, bus.out_tag_o, bus.out_taken_o, bus.out_mispred_o} !== '0)
      $display("FAIL reset_out: valid=%0d tag=%0d, required 0", bus.out_valid_o, bus.out_tag_o);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.redir_valid_o, bus.redir_pc_o} !== '0)
      $display("FAIL reset_redir: valid=%0d pc=%06h, required 0", bus.redir_valid_o, bus.redir_pc_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_cnt++;
    if (bus.in_ready_o !== 1'b1) $display("FAIL reset_ready: in_ready=%0d, required 1", bus.in_ready_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    $display("test_reset done");
  endtask

  task automatic test_correct();
    int w;
    send(5'd1, 24'h000100, 3'd2, 12'h010, 1'b1, 1'b1, 24'h000112, 1'b1, w);
    @(negedge clk_i);
    chk_cnt++;
    if (bus.out_valid_o !== 1'b0) $display("FAIL latency_early: out_valid=%0d, required 0", bus.out_valid_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    chk_cnt++;
    if (bus.out_valid_o !== 1'b1) $display("FAIL latency: out_valid=%0d, required 1", bus.out_valid_o);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk_cnt++;
      if (bus.redir_valid_o !== 1'b0) $display("FAIL correct_no_redir: redir_valid=%0d, required 0", bus.redir_valid_o);
      else pass_cnt++;
    end
    @(posedge clk_i); #1;
    $display("test_correct done");
  endtask

  task automatic test_mispredict();
    int w;
    send(5'd2, 24'h000200, 3'd3, 12'hFF8, 1'b0, 1'b1, 24'h0001FB, 1'b1, w);
    bus.redir_ack_i = 1'b1;
    send(5'd3, 24'h000300, 3'd2, 12'h000, 1'b0, 1'b0, 24'h000302, 1'b0, w);
    bus.redir_ack_i = 1'b0;
    chk_cnt++;
    if (w !== 0) $display("FAIL mispred_b2b_accept: waits=%0d, required 0", w);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk_cnt++;
      if (bus.redir_valid_o !== 1'b1) $display("FAIL hold_valid: redir_valid=%0d, required 1", bus.redir_valid_o);
      else pass_cnt++;
      chk_cnt++;
      if (bus.redir_pc_o !== 24'h000203) $display("FAIL hold_pc: redir_pc=%06h, required 000203", bus.redir_pc_o);
      else pass_cnt++;
      chk_cnt++;
      if (bus.in_ready_o !== 1'b0) $display("FAIL hold_ready: in_ready=%0d, required 0", bus.in_ready_o);
      else pass_cnt++;
    end
    @(posedge clk_i); #1;
    bus.redir_ack_i = 1'b1;
    @(posedge clk_i); #1;
    bus.redir_ack_i = 1'b0;
    chk_cnt++;
    if (bus.redir_valid_o !== 1'b0) $display("FAIL ack_release: redir_valid=%0d, required 0", bus.redir_valid_o);
    else pass_cnt++;
    chk_cnt++;
    if (bus.in_ready_o !== 1'b1) $display("FAIL ack_ready: in_ready=%0d, required 1", bus.in_ready_o);
    else pass_cnt++;
    chk_cnt++;
    if (bus.out_valid_o !== 1'b0) $display("FAIL wrong_path_dropped: out_valid=%0d, required 0", bus.out_valid_o);
    else pass_cnt++;
    $display("test_mispredict done");
  endtask

  task automatic test_back_to_back();
    int w;
    int base;
    logic [AWID-1:0] pc;
    logic [AWID-1:0] pp;
    bit seen;
    bus.out_ready_i = 1'b1;
    base = out_count;
    for (int t = 4; t < 8; t++) begin
      pc = 24'h001000 + AWID'(t * 16);
      pp = model_next(pc, 3'd4, 12'h020, t[0]);
      send(TAGW'(t), pc, 3'd4, 12'h020, t[0], t[0], pp, 1'b1, w);
      chk_cnt++;
      if (w !== 0) $display("FAIL b2b_accept tag=%0d: waits=%0d, required 0", t, w);
      else pass_cnt++;
    end
    repeat (2) @(posedge clk_i);
    #1;
    chk_cnt++;
    if (out_count - base !== 4) $display("FAIL b2b_count: outputs=%0d, required 4", out_count - base);
    else pass_cnt++;

    bus.out_ready_i = 1'b0;
    base = out_count;
    fork
      begin
        int w2;
        logic [AWID-1:0] pc2;
        logic [AWID-1:0] pp2;
        for (int t = 8; t < 12; t++) begin
          pc2 = 24'h002000 + AWID'(t * 8);
          pp2 = model_next(pc2, 3'd2, 12'hFF0, 1'b1);
          send(TAGW'(t), pc2, 3'd2, 12'hFF0, 1'b1, 1'b1, pp2, 1'b1, w2);
        end
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
          @(negedge clk_i);
          if (bus.out_valid_o) seen = 1'b1;
        end
        chk_cnt++;
        if (!seen) $display("FAIL stall_valid: out_valid=0 for 10 cycles, required 1");
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk_i);
          chk_cnt++;
          if ({bus.out_valid_o, bus.out_tag_o} !== {1'b1, 5'd8})
            $display("FAIL stall_hold: valid=%0d tag=%0d, required valid=1 tag=8", bus.out_valid_o, bus.out_tag_o);
          else pass_cnt++;
          chk_cnt++;
          if (bus.in_ready_o !== 1'b0) $display("FAIL stall_ready: in_ready=%0d, required 0", bus.in_ready_o);
          else pass_cnt++;
        end
        @(posedge clk_i); #1;
        bus.out_ready_i = 1'b1;
      end
    join
    repeat (6) @(posedge clk_i);
    #1;
    chk_cnt++;
    if (out_count - base !== 4) $display("FAIL stall_count: outputs=%0d, required 4", out_count - base);
    else pass_cnt++;
    $display("test_back_to_back done");
  endtask

  task automatic test_wrap();
    int w;
    send(5'd12, 24'hFFFFFE, 3'd2, 12'h004, 1'b1, 1'b1, 24'h000004, 1'b1, w);
    repeat (2) @(posedge clk_i);
    #1;
    chk_cnt++;
    if (bus.redir_valid_o !== 1'b0) $display("FAIL wrap_correct: redir_valid=%0d, required 0", bus.redir_valid_o);
    else pass_cnt++;
    send(5'd13, 24'hFFFFFE, 3'd2, 12'h004, 1'b1, 1'b0, 24'h000000, 1'b1, w);
    @(posedge clk_i); #1;
    chk_cnt++;
    if ({bus.redir_valid_o, bus.redir_pc_o} !== {1'b1, 24'h000004})
      $display("FAIL wrap_redir: valid=%0d pc=%06h, required valid=1 pc=000004", bus.redir_valid_o, bus.redir_pc_o);
    else pass_cnt++;
    bus.redir_ack_i = 1'b1;
    @(posedge clk_i); #1;
    bus.redir_ack_i = 1'b0;
    chk_cnt++;
    if (bus.redir_valid_o !== 1'b0) $display("FAIL wrap_ack: redir_valid=%0d, required 0", bus.redir_valid_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    $display("test_wrap done");
  endtask

  task automatic test_flush();
    int w;
    int base;
    bus.out_ready_i = 1'b0;
    send(5'd14, 24'h000400, 3'd2, 12'h040, 1'b1, 1'b0, 24'h000402, 1'b1, w);
    @(posedge clk_i); #1;
    chk_cnt++;
    if ({bus.out_valid_o, bus.redir_valid_o} !== 2'b11)
      $display("FAIL flush_pre: out_valid=%0d redir_valid=%0d, required 1 1", bus.out_valid_o, bus.redir_valid_o);
    else pass_cnt++;
    bus.flush_i = 1'b1; bus.redir_ack_i = 1'b1; bus.out_ready_i = 1'b1;
    exp_q.delete();
    @(posedge clk_i); #1;
    bus.flush_i = 1'b0; bus.redir_ack_i = 1'b0;
    chk_cnt++;
    if ({bus.out_valid_o, bus.redir_valid_o} !== 2'b00)
      $display("FAIL flush_hold: out_valid=%0d redir_valid=%0d, required 0 0", bus.out_valid_o, bus.redir_valid_o);
    else pass_cnt++;
    chk_cnt++;
    if (bus.in_ready_o !== 1'b1) $display("FAIL flush_ready: in_ready=%0d, required 1", bus.in_ready_o);
    else pass_cnt++;
    send(5'd15, 24'h000500, 3'd2, 12'h000, 1'b0, 1'b0, 24'h000502, 1'b1, w);
    chk_cnt++;
    if (w !== 0) $display("FAIL flush_new_accept: waits=%0d, required 0", w);
    else pass_cnt++;
    repeat (2) @(posedge clk_i);
    #1;

    bus.out_ready_i = 1'b0;
    send(5'd16, 24'h000600, 3'd1, 12'h000, 1'b0, 1'b0, 24'h000601, 1'b1, w);
    send(5'd17, 24'h000601, 3'd1, 12'h000, 1'b0, 1'b0, 24'h000602, 1'b1, w);
    base = out_count;
    bus.flush_i = 1'b1; bus.out_ready_i = 1'b1;
    bus.in_valid_i = 1'b1; bus.in_tag_i = 5'd18; bus.in_pc_i = 24'h000700;
    bus.in_pred_pc_i = 24'h000000;
    exp_q.delete();
    @(posedge clk_i); #1;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    chk_cnt++;
    if (bus.out_valid_o !== 1'b0) $display("FAIL flush_both: out_valid=%0d, required 0", bus.out_valid_o);
    else pass_cnt++;
    repeat (3) @(posedge clk_i);
    #1;
    chk_cnt++;
    if (out_count - base !== 0) $display("FAIL flush_leak: outputs=%0d, required 0", out_count - base);
    else pass_cnt++;
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    int w;
    int base;
    bus.out_ready_i = 1'b0;
    send(5'd19, 24'h000800, 3'd2, 12'h000, 1'b0, 1'b0, 24'h000802, 1'b1, w);
    send(5'd20, 24'h000802, 3'd2, 12'h000, 1'b0, 1'b0, 24'h000804, 1'b1, w);
    @(posedge clk_i); #1;
    base = out_count;
    @(negedge clk_i); #2;
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    chk_cnt++;
    if ({bus.out_valid_o, bus.out_tag_o, bus.redir_valid_o} !== '0)
      $display("FAIL async_reset: out_valid=%0d tag=%0d redir_valid=%0d, required 0",
               bus.out_valid_o, bus.out_tag_o, bus.redir_valid_o);
    else pass_cnt++;
    @(posedge clk_i); #3;
    rst_i = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    chk_cnt++;
    if (out_count - base !== 0) $display("FAIL reset_leak: outputs=%0d, required 0", out_count - base);
    else pass_cnt++;
    $display("test_async_reset done");
  endtask

  initial begin
    rst_i            = 1'b1;
    bus.flush_i      = 1'b0;
    bus.in_valid_i   = 1'b0;
    bus.in_tag_i     = '0;
    bus.in_pc_i      = '0;
    bus.in_len_i     = '0;
    bus.in_disp_i    = '0;
    bus.in_takb_i    = 1'b0;
    bus.in_pred_i    = 1'b0;
    bus.in_pred_pc_i = '0;
    bus.out_ready_i  = 1'b1;
    bus.redir_ack_i  = 1'b0;
    test_reset();
    test_correct();
    test_mispredict();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_async_reset();
    chk_cnt++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
